sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock first-in/first-out buffer with registered read/write pointers, a dual-port register-file store and full/empty status flags. It sits between a producer and a consumer in the same clock domain and decouples their burst rates. The head word is presented combinationally on `rdata` (first-word fall-through). Its port behaviour must match the team's behavioural FIFO model cycle-for-cycle.

## Interface
- `DSIZE`, default 8: data word width in bits.
- `ASIZE`, default 4: address width; depth = 2**ASIZE (16 words).

- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `wdata`  input  DSIZE  write data.
- `winc`  input  1  write request.
- `rinc`  input  1  read (pop) request.
- `rdata`  output  DSIZE  word at the head of the FIFO.
- `wfull`  output  1  FIFO holds 2**ASIZE words.
- `rempty`  output  1  FIFO holds 0 words.
- `level`  output  ASIZE+1  occupancy; present only with `SYNC_FIFO_LEVEL_EN`.

## Operation
- State: write pointer `wptr` and read pointer `rptr`, each ASIZE+1 bits: ASIZE address bits plus one wrap bit. Storage is `mem[0:2**ASIZE-1]` of DSIZE bits.
- Write accept: `winc && !wfull`. At the rising edge, `mem[wptr[ASIZE-1:0]] <= wdata` and `wptr <= wptr+1`.
- Read accept: `rinc && !rempty`. At the rising edge, `rptr <= rptr+1`.
- Pointer increments wrap modulo 2**(ASIZE+1). No saturation logic.
- `rempty = (wptr == rptr)`.
- `wfull = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0])`.
- Both flags decode combinationally from the registered pointers.
- `rdata = mem[rptr[ASIZE-1:0]]`, combinational. It is valid only while `rempty=0`.
- Overflow: a write while `wfull=1` is dropped. Memory and `wptr` are unchanged, even if a read is accepted in the same cycle.
- Underflow: a read while `rempty=1` is ignored and `rptr` is unchanged, even if a write is accepted in the same cycle.
- Simultaneous accepted read and write (neither flag set): both pointers advance and occupancy is unchanged.
- Reset (`rst_n=0`, asynchronous, at any time including mid-transfer):
  - `wptr=0`, `rptr=0`.
  - `rempty=1` and `wfull=0` immediately on assertion.
  - Memory contents are not reset.
  - `rdata` is undefined until the first write.
- Reset release is sampled synchronously. The first accepted operation occurs on the first rising edge where `rst_n=1`.

## Timing
- Write-to-read latency is 1 cycle. A word written at edge N appears on `rdata`, with `rempty=0`, immediately after edge N.
- Pop latency is 0. `rdata` advances to the next word right after the edge that accepts the read.
- Flags update in the same cycle as the pointer edge. There is no extra pipeline stage.
- The FIFO sustains full throughput: one write and one read per cycle.
- Reset values: `rempty=1`, `wfull=0`, `level=0`, `rdata=X`.

## Configuration
- Macro: `SYNC_FIFO_LEVEL_EN`.
- Defined: adds output `level = wptr - rptr` (ASIZE+1 bits, modulo arithmetic, range 0..2**ASIZE), combinational from the pointers.
- Not defined: the `level` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: assert `rst_n=0` for 2 cycles -> `rempty=1`, `wfull=0`, `level=0`. Then drive `rinc=1` for 3 cycles with the FIFO empty -> flags unchanged and `rptr` stays 0.
- Fill: write 0x10..0x1F on 16 consecutive cycles -> `wfull=1` after the 16th edge and `level=16`. A 17th write of 0xAA is dropped.
- Drain: hold `rinc` for 16 cycles -> `rdata` sequence 0x10..0x1F. `rempty=1` after the 16th edge. A 17th read leaves the pointers unchanged.
- Wrap-around: run 40 writes interleaved with reads using random data -> all data is returned in order, and flags stay correct across pointer wrap (wrap bit toggles).
- Simultaneous read/write:
  - At level 5, with `winc` and `rinc` both high for 10 cycles -> level stays 5 and order is preserved.
  - At full with both high -> read accepted, write dropped, level becomes 15.
- Mid-operation reset: at level 7, pulse `rst_n` low between edges -> `rempty=1` and `wfull=0` immediately. After release, a write of 0x5C is read back first.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with registered pointers and full/empty flags.
// Define SYNC_FIFO_LEVEL_EN to add the `level` occupancy output.
module sync_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
`ifdef SYNC_FIFO_LEVEL_EN
  ,
  output logic [ASIZE:0]   level
`endif
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_r [0:DEPTH-1];
  logic [ASIZE:0]   wptr_r;
  logic [ASIZE:0]   rptr_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Flags, accept qualifiers and head word decode straight from the registered pointers.
  always_comb begin
    rempty  = (wptr_r == rptr_r);
    wfull   = (wptr_r[ASIZE] != rptr_r[ASIZE]) &&
              (wptr_r[ASIZE-1:0] == rptr_r[ASIZE-1:0]);
    wr_en_s = winc && !wfull;
    rd_en_s = rinc && !rempty;
    rdata   = mem_r[rptr_r[ASIZE-1:0]];
  end

`ifdef SYNC_FIFO_LEVEL_EN
  // Occupancy in modulo arithmetic; the wrap bit makes a full FIFO read as 2**ASIZE.
  always_comb begin
    level = wptr_r - rptr_r;
  end
`endif

  // Pointer registers; the wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {(ASIZE+1){1'b0}};
      rptr_r <= {(ASIZE+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wptr_r <= wptr_r + (ASIZE+1)'(1);
      end
      if (rd_en_s) begin
        rptr_r <= rptr_r + (ASIZE+1)'(1);
      end
    end
  end

  // Storage array is deliberately not reset; rst_n gating keeps writes out while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en_s && rst_n) begin
      mem_r[wptr_r[ASIZE-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed and random traffic against a queue-based reference model.
// Compile with SYNC_FIFO_LEVEL_EN defined to also check the level output.
module tb_sync_fifo;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst_n;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [ASIZE:0]   level;
`endif

  int n_cmp;
  int n_bad;
  logic [DSIZE-1:0] model_q [$];

  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output with what the model queue implies.
  task automatic check_state(input string tag);
    chk({tag, ".rempty"}, 32'(rempty), 32'(model_q.size() == 0));
    chk({tag, ".wfull"},  32'(wfull),  32'(model_q.size() == DEPTH));
`ifdef SYNC_FIFO_LEVEL_EN
    chk({tag, ".level"},  32'(level),  32'(model_q.size()));
`endif
    if (model_q.size() != 0) begin
      chk({tag, ".rdata"}, 32'(rdata), 32'(model_q[0]));
    end
  endtask

  // One clock: apply inputs, update the model on the edge, check 1 time unit later.
  task automatic step(input string tag, input logic w, input logic r, input logic [DSIZE-1:0] d);
    bit wr_ok;
    bit rd_ok;
    winc  = w;
    rinc  = r;
    wdata = d;
    wr_ok = w && (model_q.size() < DEPTH);
    rd_ok = r && (model_q.size() > 0);
    @(posedge clk);
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    check_state(tag);
  endtask

  initial begin
    int writes;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;

    // Reset held for two cycles, then idle reads on an empty FIFO.
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("underflow", 1'b0, 1'b1, 8'h00);

    // Fill with 0x10..0x1F, then a dropped overflow write.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(8'h10 + i));
    chk("fill.full", 32'(wfull), 32'd1);
    step("overflow", 1'b1, 1'b0, 8'hAA);

    // Drain all 16 plus one ignored read.
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.seq", 32'(rdata), 32'(8'h10 + i));
      step("drain", 1'b0, 1'b1, 8'h00);
    end
    chk("drain.empty", 32'(rempty), 32'd1);
    step("underflow2", 1'b0, 1'b1, 8'h00);

    // Random interleaved traffic across pointer wrap, then drain.
    writes = 0;
    while (writes < 40) begin
      logic w;
      w = ($urandom_range(0, 3) != 0);
      if (w) writes++;
      step("wrap", w, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    while (model_q.size() > 0) step("wrap.drain", 1'b0, 1'b1, 8'h00);

    // Level 5, then simultaneous read/write for 10 cycles.
    for (int i = 0; i < 5; i++) step("lvl5.fill", 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) step("simul5", 1'b1, 1'b1, 8'($urandom));
    chk("simul5.size", 32'(model_q.size()), 32'd5);

    // Full with both requests: read accepted, write dropped.
    while (model_q.size() < DEPTH) step("tofull", 1'b1, 1'b0, 8'($urandom));
    step("full.rw", 1'b1, 1'b1, 8'hEE);
    chk("full.rw.size", 32'(model_q.size()), 32'd15);

    // Down to level 7, then asynchronous reset pulse between edges.
    while (model_q.size() > 7) step("to7", 1'b0, 1'b1, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    chk("midrst.rempty", 32'(rempty), 32'd1);
    chk("midrst.wfull",  32'(wfull),  32'd0);
`ifdef SYNC_FIFO_LEVEL_EN
    chk("midrst.level",  32'(level),  32'd0);
`endif
    rst_n = 1'b1;
    step("postrst.wr", 1'b1, 1'b0, 8'h5C);
    chk("postrst.rdata", 32'(rdata), 32'h5C);
    step("postrst.rd", 1'b0, 1'b1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
